// File: rtl/shift_rot_seq_pkg.sv
// rtl/shift_rot_seq_pkg.sv - shared op/state encodings for the sequential shift/rotate unit
package shift_rot_seq_pkg;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // op[1] selects direction (0 = left), op[0] selects zero-fill (0 = wrap).
  function automatic logic op_is_left(input logic [1:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  function automatic logic op_is_rotate(input logic [1:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// rtl/shift_stage_mux.sv - one barrel stage: move data by 2^k in the op's direction when enabled
module shift_stage_mux
  import shift_rot_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNTW-1:0]  i_k,
  input  logic             i_en,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_data
);

  // Stage amount is at most WIDTH/2, so WIDTH-amt never reaches zero or WIDTH.
  logic [CNTW:0]      w_amt;
  logic [CNTW:0]      w_inv;
  logic [WIDTH-1:0]   w_left;
  logic [WIDTH-1:0]   w_right;
  logic [WIDTH-1:0]   w_wrap_l;
  logic [WIDTH-1:0]   w_wrap_r;

  assign w_amt    = (CNTW+1)'(1) << i_k;
  assign w_inv    = (CNTW+1)'(WIDTH) - w_amt;
  assign w_left   = i_data << w_amt;
  assign w_right  = i_data >> w_amt;
  assign w_wrap_l = i_data >> w_inv;
  assign w_wrap_r = i_data << w_inv;

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      if (op_is_left(i_op)) begin
        o_data = op_is_rotate(i_op) ? (w_left | w_wrap_l) : w_left;
      end else begin
        o_data = op_is_rotate(i_op) ? (w_right | w_wrap_r) : w_right;
      end
    end
  end

endmodule

// File: rtl/shift_rot_seq.sv
// rtl/shift_rot_seq.sv - multi-cycle shift/rotate unit, one barrel stage per clock
// SHIFT_ROT_SEQ_EARLY_EN: finish as soon as no higher count bits remain set.
module shift_rot_seq
  import shift_rot_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNTW-1:0]  in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_out;
  logic [CNTW-1:0]  r_cnt;
  logic [CNTW-1:0]  r_k;
  logic [1:0]       r_op;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_stage;
  logic             w_last;

  shift_stage_mux #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_stage (
    .i_data (r_data),
    .i_k    (r_k),
    .i_en   (r_cnt[r_k]),
    .i_op   (r_op),
    .o_data (w_stage)
  );

`ifdef SHIFT_ROT_SEQ_EARLY_EN
  assign w_last = (r_k == CNTW'(CNTW-1)) || (((r_cnt >> r_k) >> 1) == '0);
`else
  assign w_last = (r_k == CNTW'(CNTW-1));
`endif

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

  // r_out is only written on stage edges so the result stays frozen through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_op        <= OP_ROL;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_cnt   <= in_cnt;
            r_op    <= in_op;
            r_k     <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_data <= w_stage;
          r_out  <= w_stage;
          if (w_last) begin
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_rot_seq.md
# shift_rot_seq

Parametrised, multi-cycle shift/rotate unit for the execute stage. It applies one logarithmic barrel stage per clock, so a WIDTH-bit operand needs log2(WIDTH) cycles. Operations are rotate-left, shift-left, rotate-right and shift-right-logical. Operands enter and results leave through valid/ready handshakes, which lets the pipeline stall around the unit.

## Interface
- WIDTH, 16: operand width. Must be a power of two and at least 2.
- CNTW, $clog2(WIDTH): shift-amount width. Derived only; never overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand and command present.
- in_ready  out  1  unit can accept a command.
- in_data  in  WIDTH  operand.
- in_cnt  in  CNTW  shift/rotate amount, 0..WIDTH-1.
- in_op  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  result; stable while out_valid=1.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !rst.
- out_valid = (state==DONE).
- **IDLE:** when in_valid && in_ready, capture in_data, in_cnt and in_op into registers, set stage index k=0, and go to SHIFT. in_data is captured as-is.
- **SHIFT:** each edge applies stage k to the data register.
  - If cnt_reg[k]=1, the data moves by 2^k in the direction given by op_reg. If cnt_reg[k]=0, the data passes unchanged.
  - ROL/ROR wrap vacated bits around. SLL/SRL zero-fill.
  - Advance k. After stage CNTW-1 the FSM goes to DONE.
- **DONE:** out_data holds the result. On out_valid && out_ready the FSM goes to IDLE, and in_ready rises on the following cycle. There is no same-cycle result-to-accept bypass.
- Count wrap: in_cnt is CNTW bits, so no amount of WIDTH or more exists. ROR by 0 and ROL by 0 return the operand unchanged.
- in_valid outside IDLE is ignored; the producer must hold it until in_ready.
- Reset takes priority over everything, including a mid-SHIFT or DONE operation. It drops the operation with no output.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, k=0.
  - in_ready=0 while rst is high, then 1 on the first cycle after deassertion.

## Timing
- Accept edge at cycle T, so SHIFT begins at T+1.
- out_valid rises at T+CNTW; for WIDTH=16 that is 4 cycles after acceptance.
- out_data changes only on SHIFT edges. It is frozen through DONE regardless of out_ready.
- Minimum initiation interval is CNTW+2 cycles: accept, CNTW stages, handoff. With out_ready tied high, throughput is one result per CNTW+2 cycles.
- Back-pressure (out_ready=0) holds DONE indefinitely with in_ready=0.
- in_ready, out_valid and out_data are registered/state-decoded. There are no combinational paths from in_* to out_*.

## Configuration
- Macro: SHIFT_ROT_SEQ_EARLY_EN.
- **Defined:** after applying stage k, if k==CNTW-1 or cnt_reg[CNTW-1:k+1]==0, go to DONE.
  - Latency = max(1, index of highest set bit of in_cnt + 1). Example: cnt=0 gives 1 cycle; cnt=1 gives 1; cnt=5 gives 3.
- **Undefined:** fixed latency of CNTW cycles for every command.
- Result values are identical in both builds.

## Structure
- Package shift_rot_seq_pkg holds:
  - the op enum (OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11);
  - the FSM state enum (S_IDLE, S_SHIFT, S_DONE).
- One combinational sub-module, shift_stage_mux. It is parametrised by WIDTH and CNTW.
  - Inputs: data, stage index k, enable bit, op.
  - Output: the data shifted/rotated by 2^k when enabled.
- The top level holds the FSM, the operand/count/op registers and the stage counter.

## Test plan
- ROL, in_data=0x1234, in_cnt=4, out_ready=1 -> out_valid at T+4 with out_data=0x2341; in_ready returns 1 cycle after handoff.
- SLL 0x8001 cnt 15 -> 0x8000; SRL 0x8000 cnt 15 -> 0x0001; ROR 0x0001 cnt 1 -> 0x8000; any op with cnt 0 returns the operand unchanged.
- Back-pressure: ROL 0x00FF cnt 8, out_ready low for 3 cycles after out_valid -> out_data held at 0xFF00, in_ready=0 and new in_valid ignored throughout; handoff on the 4th cycle.
- Reset mid-SHIFT (2 cycles after accepting SRL 0xF000 cnt 12) -> the next cycle shows out_valid=0 and out_data=0, in_ready=1 after rst drops, and no result is ever emitted.
- Back-to-back: 3 commands with in_valid held high -> accepted at cycles 0, 6, 12 (WIDTH=16), and results arrive in order.
- With SHIFT_ROT_SEQ_EARLY_EN: ROL 0xABCD cnt 1 -> out_valid at T+1 with 0x579B; cnt 0 -> out_valid at T+1 with 0xABCD.
